// File: rtl/vga_timing_gen_if.sv
// Pixel-timing bundle from the VGA timing generator to the rendering stages.
// The master side drives coordinates, blanking, syncs and strobes; the slave side consumes them.
interface vga_timing_gen_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       hs;
  logic       vs;
  logic       line_done;
  logic       frame_done;
  logic [7:0] frame_count;

  modport master (
    output DrawX, DrawY, blank, hs, vs, line_done, frame_done, frame_count
  );

  modport slave (
    input DrawX, DrawY, blank, hs, vs, line_done, frame_done, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA pixel-timing generator: raster counters, visible-area decode,
// pipeline-aligned active-low syncs, and line/frame strobes with a frame counter.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 1
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Window bounds are 11 bits so a bound of exactly 1024 still compares correctly.
  localparam logic [10:0] H_VIS_END    = 11'(H_VISIBLE);
  localparam logic [10:0] H_SYNC_START = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] H_SYNC_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS_END    = 11'(V_VISIBLE);
  localparam logic [10:0] V_SYNC_START = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] V_SYNC_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] hc_r;
  logic [9:0] vc_r;
  logic [7:0] frame_count_r;

  logic line_done_s;
  logic frame_done_s;
  logic blank_s;
  logic hs_raw_s;
  logic vs_raw_s;
  logic hs_s;
  logic vs_s;

  // Raster decode straight from the registered counters.
  always_comb begin
    line_done_s  = (hc_r == H_LAST);
    frame_done_s = line_done_s && (vc_r == V_LAST);
    blank_s      = ({1'b0, hc_r} < H_VIS_END) && ({1'b0, vc_r} < V_VIS_END);
    hs_raw_s     = !(({1'b0, hc_r} >= H_SYNC_START) && ({1'b0, hc_r} < H_SYNC_END));
    vs_raw_s     = !(({1'b0, vc_r} >= V_SYNC_START) && ({1'b0, vc_r} < V_SYNC_END));
  end

  // Horizontal/vertical raster counters and completed-frame counter.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_r          <= 10'd0;
      vc_r          <= 10'd0;
      frame_count_r <= 8'd0;
    end else begin
      if (line_done_s) begin
        hc_r <= 10'd0;
        if (frame_done_s) begin
          vc_r          <= 10'd0;
          frame_count_r <= frame_count_r + 8'd1;
        end else begin
          vc_r <= vc_r + 10'd1;
        end
      end else begin
        hc_r <= hc_r + 10'd1;
      end
    end
  end

  generate
    if (PIPE_DELAY == 0) begin : g_no_delay
      assign hs_s = hs_raw_s;
      assign vs_s = vs_raw_s;
    end else begin : g_delay
      logic [PIPE_DELAY-1:0] hs_pipe_r;
      logic [PIPE_DELAY-1:0] vs_pipe_r;

      // Sync delay chain; reset loads the inactive level so no stale pulse survives a reset.
      always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
          hs_pipe_r <= '1;
          vs_pipe_r <= '1;
        end else begin
          hs_pipe_r[0] <= hs_raw_s;
          vs_pipe_r[0] <= vs_raw_s;
          for (int i = 1; i < PIPE_DELAY; i++) begin
            hs_pipe_r[i] <= hs_pipe_r[i-1];
            vs_pipe_r[i] <= vs_pipe_r[i-1];
          end
        end
      end

      assign hs_s = hs_pipe_r[PIPE_DELAY-1];
      assign vs_s = vs_pipe_r[PIPE_DELAY-1];
    end
  endgenerate

  assign vga.DrawX       = hc_r;
  assign vga.DrawY       = vc_r;
  assign vga.blank       = blank_s;
  assign vga.hs          = hs_s;
  assign vga.vs          = vs_s;
  assign vga.line_done   = line_done_s;
  assign vga.frame_done  = frame_done_s;
  assign vga.frame_count = frame_count_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three reduced-raster instances (sync delay 0, 1, 3)
// plus one default 640x480 instance, with expectations derived from the cycle index.
module tb_vga_timing_gen;

  // Reduced raster: 16 x 10 totals, hs low at hc 10..13, vs low at vc 7..8.
  localparam int SH_VIS  = 8;
  localparam int SH_FP   = 2;
  localparam int SH_SYNC = 4;
  localparam int SH_BP   = 2;
  localparam int SV_VIS  = 6;
  localparam int SV_FP   = 1;
  localparam int SV_SYNC = 2;
  localparam int SV_BP   = 1;
  localparam int S_HT    = 16;
  localparam int S_FRAME = 160;
  localparam int N_LONG  = 256 * S_FRAME;
  localparam int N_MID   = 8 * S_HT + 13;  // hc=13, vc=8: hs and vs low on every small instance

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       ld;
    logic       fd;
    logic [7:0] fc;
  } obs_t;

  typedef struct {
    int   dut;
    int   n;
    obs_t exp;
  } exp_t;

  exp_t exp_q[$];

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   n_cur = -1;
  bit   phase2 = 1'b0;
  int   fd_cnt = 0;
  int   blank_cnt = 0;
  int   vs_low_cnt = 0;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen_if if_d0 ();
  vga_timing_gen_if if_d1 ();
  vga_timing_gen_if if_d3 ();
  vga_timing_gen_if if_def ();

  vga_timing_gen #(
    .H_VISIBLE(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
    .V_VISIBLE(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP), .PIPE_DELAY(0)
  ) dut_d0 (.vga_clk(vga_clk), .reset_n(reset_n), .vga(if_d0));

  vga_timing_gen #(
    .H_VISIBLE(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
    .V_VISIBLE(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP), .PIPE_DELAY(1)
  ) dut_d1 (.vga_clk(vga_clk), .reset_n(reset_n), .vga(if_d1));

  vga_timing_gen #(
    .H_VISIBLE(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
    .V_VISIBLE(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP), .PIPE_DELAY(3)
  ) dut_d3 (.vga_clk(vga_clk), .reset_n(reset_n), .vga(if_d3));

  vga_timing_gen dut_def (.vga_clk(vga_clk), .reset_n(reset_n), .vga(if_def));

  obs_t act [4];
  assign act[0] = {if_d0.DrawX, if_d0.DrawY, if_d0.blank, if_d0.hs, if_d0.vs,
                   if_d0.line_done, if_d0.frame_done, if_d0.frame_count};
  assign act[1] = {if_d1.DrawX, if_d1.DrawY, if_d1.blank, if_d1.hs, if_d1.vs,
                   if_d1.line_done, if_d1.frame_done, if_d1.frame_count};
  assign act[2] = {if_d3.DrawX, if_d3.DrawY, if_d3.blank, if_d3.hs, if_d3.vs,
                   if_d3.line_done, if_d3.frame_done, if_d3.frame_count};
  assign act[3] = {if_def.DrawX, if_def.DrawY, if_def.blank, if_def.hs, if_def.vs,
                   if_def.line_done, if_def.frame_done, if_def.frame_count};

  // Expected outputs n cycles after reset release, computed from the raster arithmetic.
  function automatic obs_t model(int n, int d, int hv, int hfp, int hsw, int hbp,
                                 int vv, int vfp, int vsw, int vbp);
    obs_t o;
    int ht = hv + hfp + hsw + hbp;
    int vt = vv + vfp + vsw + vbp;
    int h  = n % ht;
    int v  = (n / ht) % vt;
    int hm;
    int vm;
    o.x     = 10'(h);
    o.y     = 10'(v);
    o.blank = (h < hv) && (v < vv);
    o.ld    = (h == ht - 1);
    o.fd    = (h == ht - 1) && (v == vt - 1);
    o.fc    = 8'((n / (ht * vt)) % 256);
    if (n < d) begin
      o.hs = 1'b1;
      o.vs = 1'b1;
    end else begin
      hm   = (n - d) % ht;
      vm   = ((n - d) / ht) % vt;
      o.hs = !((hm >= hv + hfp) && (hm < hv + hfp + hsw));
      o.vs = !((vm >= vv + vfp) && (vm < vv + vfp + vsw));
    end
    return o;
  endfunction

  function automatic obs_t reset_obs();
    obs_t o;
    o.x     = 10'd0;
    o.y     = 10'd0;
    o.blank = 1'b1;
    o.hs    = 1'b1;
    o.vs    = 1'b1;
    o.ld    = 1'b0;
    o.fd    = 1'b0;
    o.fc    = 8'd0;
    return o;
  endfunction

  task automatic push_all(input int n);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.dut = k;
      e.n   = n;
      if (n < 0) begin
        e.exp = reset_obs();
      end else if (k == 3) begin
        e.exp = model(n, 1, 640, 16, 96, 48, 480, 10, 2, 33);
      end else begin
        e.exp = model(n, (k == 0) ? 0 : ((k == 1) ? 1 : 3),
                      SH_VIS, SH_FP, SH_SYNC, SH_BP, SV_VIS, SV_FP, SV_SYNC, SV_BP);
      end
      exp_q.push_back(e);
    end
  endtask

  // Monitor: pop every expectation queued for this cycle and compare; gather frame statistics.
  always @(negedge vga_clk) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act[e.dut] !== e.exp) begin
        errors++;
        $display("FAIL sample dut%0d n=%0d actual x=%0d y=%0d blank=%0b hs=%0b vs=%0b ld=%0b fd=%0b fc=%0d required x=%0d y=%0d blank=%0b hs=%0b vs=%0b ld=%0b fd=%0b fc=%0d",
                 e.dut, e.n,
                 act[e.dut].x, act[e.dut].y, act[e.dut].blank, act[e.dut].hs, act[e.dut].vs,
                 act[e.dut].ld, act[e.dut].fd, act[e.dut].fc,
                 e.exp.x, e.exp.y, e.exp.blank, e.exp.hs, e.exp.vs,
                 e.exp.ld, e.exp.fd, e.exp.fc);
      end
    end
    if (phase2 && n_cur >= 0) begin
      if (n_cur < N_LONG && act[1].fd) fd_cnt++;
      if (n_cur < S_FRAME && act[1].blank) blank_cnt++;
      if (n_cur >= 1 && n_cur <= S_FRAME && !act[1].vs) vs_low_cnt++;
    end
  end

  task automatic check_int(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    n_cur   = -1;
    repeat (5) begin
      @(posedge vga_clk);
      #1;
      push_all(-1);
    end
    @(posedge vga_clk);
    #1;
    reset_n = 1'b1;
    for (int n = 0; n < N_MID; n++) begin
      n_cur = n;
      push_all(n);
      @(posedge vga_clk);
      #1;
    end
    // Counters now sit at hc=13, vc=8 with both syncs low; reset lands mid-cycle.
    reset_n = 1'b0;
    n_cur   = -1;
    push_all(-1);
    repeat (2) begin
      @(posedge vga_clk);
      #1;
      push_all(-1);
    end
    @(posedge vga_clk);
    #1;
    reset_n = 1'b1;
    phase2  = 1'b1;
    for (int n = 0; n <= N_LONG + 40; n++) begin
      n_cur = n;
      if (n < 2000 || n >= N_LONG - 2 * S_FRAME) push_all(n);
      @(posedge vga_clk);
      #1;
    end
    @(negedge vga_clk);
    #1;
    check_int("frame_done_pulses_256_frames", fd_cnt, 256);
    check_int("blank_high_cycles_per_frame", blank_cnt, SH_VIS * SV_VIS);
    check_int("vs_low_cycles_per_frame", vs_low_cnt, SV_SYNC * S_HT);
    check_int("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
